// File: rtl/tmds_rx_channel_if.sv
// Parallel-side bus of one TMDS receive channel: raw deserialized words in,
// decoded symbol stream out. `lock_loss_cnt` exists only with TMDS_RX_STATS_EN.
interface tmds_rx_channel_if;
  logic [9:0] raw_data;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] align_offset;
`ifdef TMDS_RX_STATS_EN
  logic [7:0] lock_loss_cnt;

  modport master (
    output raw_data,
    input  data, ctrl, de, locked, align_offset, lock_loss_cnt
  );

  modport slave (
    input  raw_data,
    output data, ctrl, de, locked, align_offset, lock_loss_cnt
  );
`else
  modport master (
    output raw_data,
    input  data, ctrl, de, locked, align_offset
  );

  modport slave (
    input  raw_data,
    output data, ctrl, de, locked, align_offset
  );
`endif
endinterface

// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: word alignment by control-token hunting, then symbol decode.
// Optional macro TMDS_RX_STATS_EN adds a saturating lock-loss counter output.
module tmds_rx_channel #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_CYCLES = 4096,
  parameter int LOSS_CYCLES   = 4096
) (
  input logic              pixel_clk,
  input logic              rst,
  tmds_rx_channel_if.slave rx
);

  localparam int ST_W = $clog2(SEARCH_CYCLES + 1);
  localparam int LT_W = $clog2(LOSS_CYCLES + 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_VERIFY,
    S_LOCKED
  } state_t;

  logic [9:0]      raw_q;
  logic [9:0]      raw_prev;
  logic [9:0]      win;
  logic [19:0]     pair;

  state_t          state;
  state_t          state_d;
  logic [3:0]      offset;
  logic [3:0]      offset_d;
  logic [7:0]      tok_cnt;
  logic [7:0]      tok_cnt_d;
  logic [ST_W-1:0] search_cnt;
  logic [ST_W-1:0] search_cnt_d;
  logic [LT_W-1:0] loss_cnt;
  logic [LT_W-1:0] loss_cnt_d;

  logic            is_token;
  logic [1:0]      token_ctrl;
  logic [7:0]      d_unmasked;
  logic [7:0]      pixel;

  logic [7:0]      data_d;
  logic [7:0]      data_q;
  logic [1:0]      ctrl_d;
  logic [1:0]      ctrl_q;
  logic            de_d;
  logic            de_q;
  logic            locked_q;

  // Older word in the low half: bit 0 of the pair is the earliest received bit.
  assign pair = {raw_q, raw_prev};

  // ---------------------------------------------------------------- symbol decode
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    is_token   = 1'b1;
    token_ctrl = 2'b00;
    case (win)
      10'h354: token_ctrl = 2'b00;
      10'h0AB: token_ctrl = 2'b01;
      10'h154: token_ctrl = 2'b10;
      10'h2AB: token_ctrl = 2'b11;
      default: is_token   = 1'b0;
    endcase
  end

  always_comb begin
    d_unmasked = win[9] ? ~win[7:0] : win[7:0];
    pixel      = '0;
    pixel[0]   = d_unmasked[0];
    for (int i = 1; i < 8; i++) begin
      pixel[i] = win[8] ? (d_unmasked[i] ^ d_unmasked[i-1])
                        : ~(d_unmasked[i] ^ d_unmasked[i-1]);
    end
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      raw_q      <= '0;
      raw_prev   <= '0;
      win        <= '0;
      state      <= S_SEARCH;
      offset     <= '0;
      tok_cnt    <= '0;
      search_cnt <= '0;
      loss_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values,
      // which is what makes raw_q -> raw_prev a real two-stage shift.
      raw_q      <= rx.raw_data;
      raw_prev   <= raw_q;
      win        <= pair[{1'b0, offset} +: 10];
      state      <= state_d;
      offset     <= offset_d;
      tok_cnt    <= tok_cnt_d;
      search_cnt <= search_cnt_d;
      loss_cnt   <= loss_cnt_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d      = state;
    offset_d     = offset;
    tok_cnt_d    = tok_cnt;
    search_cnt_d = search_cnt;
    loss_cnt_d   = loss_cnt;

    if (state == S_LOCKED) begin
      search_cnt_d = '0;
      if (is_token) begin
        loss_cnt_d = '0;
      end else if (loss_cnt == LT_W'(LOSS_CYCLES - 1)) begin
        state_d    = S_SEARCH;
        loss_cnt_d = '0;
      end else begin
        loss_cnt_d = loss_cnt + 1'b1;
      end
    end else if (search_cnt == ST_W'(SEARCH_CYCLES - 1)) begin
      // Dwell expiry takes priority over a token seen on the same cycle.
      state_d      = S_SEARCH;
      offset_d     = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
      search_cnt_d = '0;
      tok_cnt_d    = '0;
    end else begin
      search_cnt_d = search_cnt + 1'b1;
      if (!is_token) begin
        state_d   = S_SEARCH;
        tok_cnt_d = '0;
      end else if (state == S_SEARCH) begin
        state_d   = S_VERIFY;
        tok_cnt_d = 8'd1;
      end else if (tok_cnt == 8'(LOCK_TOKENS - 1)) begin
        state_d      = S_LOCKED;
        tok_cnt_d    = '0;
        search_cnt_d = '0;
        loss_cnt_d   = '0;
      end else begin
        tok_cnt_d = tok_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Gated by the next state so the lock-completing symbol is already marked locked.
  always_comb begin
    data_d = '0;
    ctrl_d = '0;
    de_d   = 1'b0;
    if (state_d == S_LOCKED) begin
      if (is_token) begin
        ctrl_d = token_ctrl;
      end else begin
        de_d   = 1'b1;
        data_d = pixel;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
      locked_q <= (state_d == S_LOCKED);
    end
  end

  assign rx.data         = data_q;
  assign rx.ctrl         = ctrl_q;
  assign rx.de           = de_q;
  assign rx.locked       = locked_q;
  assign rx.align_offset = offset;

`ifdef TMDS_RX_STATS_EN
  logic [7:0] loss_events;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      loss_events <= '0;
    end else if (state == S_LOCKED && state_d == S_SEARCH && loss_events != 8'hFF) begin
      loss_events <= loss_events + 8'd1;
    end
  end

  assign rx.lock_loss_cnt = loss_events;
`endif

  offset_in_range: assert property (@(posedge pixel_clk) disable iff (rst) offset <= 4'd9);
  de_only_when_locked: assert property (@(posedge pixel_clk) disable iff (rst) de_q |-> locked_q);

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: randomized streams compared each cycle
// against a bit-history reference model, plus fixed-point checks of key timings.
`timescale 1ns/1ps
module tb_tmds_rx_channel;

  localparam int LOCK_TOKENS   = 8;
  localparam int SEARCH_CYCLES = 4096;
  localparam int LOSS_CYCLES   = 4096;

  logic pixel_clk;
  logic rst;

  tmds_rx_channel_if bus ();

  tmds_rx_channel #(
    .LOCK_TOKENS  (LOCK_TOKENS),
    .SEARCH_CYCLES(SEARCH_CYCLES),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst      (rst),
    .rx       (bus)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: history of every word applied since reset and the
  // alignment offset in force after each edge.
  logic [9:0] words[$];
  int         offs[$];
  bit         m_locked;
  int         m_streak, m_dwell, m_quiet, m_off, m_losses;
  logic [9:0] m_sym;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  logic       e_de;

  function automatic int token_code(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  // Undo the XOR/XNOR chain: each data bit is the transition between adjacent d bits.
  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    d = s[9] ? ~s[7:0] : s[7:0];
    return d ^ {d[6:0], 1'b0} ^ (s[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [9:0] word_at(input int i);
    return (i < 0) ? 10'h000 : words[i];
  endfunction

  function automatic int off_at(input int i);
    return (i < 0) ? 0 : offs[i];
  endfunction

  function automatic logic [9:0] random_data_word();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (token_code(w) >= 0);
    return w;
  endfunction

  task automatic model_reset();
    words.delete();
    offs.delete();
    m_locked = 0;
    m_streak = 0;
    m_dwell  = 0;
    m_quiet  = 0;
    m_off    = 0;
    m_losses = 0;
    e_data   = '0;
    e_ctrl   = '0;
    e_de     = 1'b0;
  endtask

  // Edge n shows the symbol spanning words n-3 (low) and n-2 (high), cut at the
  // offset that was in force after edge n-2.
  task automatic model_step(input logic [9:0] w);
    int         n;
    int         tc;
    logic [19:0] both;
    n = words.size();
    words.push_back(w);
    both  = {word_at(n - 2), word_at(n - 3)};
    m_sym = 10'(both >> off_at(n - 2));
    tc    = token_code(m_sym);
    if (!m_locked) begin
      m_dwell++;
      if (m_dwell == SEARCH_CYCLES) begin
        m_off    = (m_off + 1) % 10;
        m_dwell  = 0;
        m_streak = 0;
      end else if (tc >= 0) begin
        m_streak++;
        if (m_streak == LOCK_TOKENS) begin
          m_locked = 1;
          m_dwell  = 0;
          m_streak = 0;
          m_quiet  = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (tc >= 0) m_quiet = 0;
      else         m_quiet++;
      if (m_quiet == LOSS_CYCLES) begin
        m_locked = 0;
        m_quiet  = 0;
        m_dwell  = 0;
        if (m_losses < 255) m_losses++;
      end
    end
    offs.push_back(m_off);
    e_de   = m_locked && (tc < 0);
    e_ctrl = (m_locked && tc >= 0) ? 2'(tc) : 2'b00;
    e_data = e_de ? tmds_decode(m_sym) : 8'h00;
  endtask

  function automatic logic [15:0] dut_outputs();
    return {bus.locked, bus.de, bus.ctrl, bus.data, bus.align_offset};
  endfunction

  function automatic logic [15:0] model_outputs();
    return {m_locked, e_de, e_ctrl, e_data, 4'(m_off)};
  endfunction

  // Drive one word, let the DUT take the edge, then advance the model.
  task automatic cycle(input logic [9:0] w);
    bus.raw_data = w;
    @(posedge pixel_clk);
    #1;
    model_step(w);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    bus.raw_data = 10'h354;
    rst = 1'b1;
    repeat (2) @(posedge pixel_clk);
    #1;
    vectors++;
    if (dut_outputs() !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected 0000", dut_outputs());
    end
`ifdef TMDS_RX_STATS_EN
    vectors++;
    if (bus.lock_loss_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_loss_cnt: got %h, expected 00", bus.lock_loss_cnt);
    end
`endif
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_aligned_lock();
    for (int i = 0; i < 48; i++) begin
      cycle(i < 16 ? 10'h354 : random_data_word());
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL aligned_stream cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
      if (i == 9) begin
        vectors++;
        if (bus.locked !== 1'b0) begin
          miscompares++;
          $display("FAIL aligned_early_lock: got locked=%b, expected 0", bus.locked);
        end
      end
      if (i == 10) begin
        vectors++;
        if (dut_outputs() !== 16'h8000) begin
          miscompares++;
          $display("FAIL aligned_lock_edge: got %h, expected 8000", dut_outputs());
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [9:0]  stim[6] = '{10'h100, 10'h2FF, 10'h2AB, 10'h354, 10'h354, 10'h354};
    logic [15:0] want[3] = '{16'hC000, 16'hCFE0, 16'hB000};
    for (int i = 0; i < 6; i++) begin
      cycle(stim[i]);
      if (i >= 3) begin
        vectors++;
        if (dut_outputs() !== want[i-3]) begin
          miscompares++;
          $display("FAIL decode_%h: got %h, expected %h", stim[i-3], dut_outputs(), want[i-3]);
        end
      end
    end
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 7) == 0) ? 10'(token_code(10'h0) + 0) | 10'h354 : 10'($urandom_range(0, 1023)));
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL decode_random cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
    end
  endtask

  task automatic test_aborted_verify();
    logic [9:0] w;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      if (i < 5)       w = 10'h354;
      else if (i == 5) w = 10'h100;
      else if (i < 14) w = 10'h354;
      else             w = random_data_word();
      cycle(w);
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL abort_stream cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
      if (i == 15 || i == 16) begin
        vectors++;
        if (bus.locked !== (i == 16)) begin
          miscompares++;
          $display("FAIL abort_lock_time cyc=%0d: got locked=%b, expected %b", i, bus.locked, i == 16);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    bit          sbits[$];
    logic [9:0]  tw;
    logic [9:0]  rw;
    int          budget;
    bit          got_lock;
    apply_reset();
    for (int b = 0; b < 3; b++) sbits.push_back(1'($urandom_range(0, 1)));
    budget   = 3 * SEARCH_CYCLES + 200;
    got_lock = 0;
    for (int i = 0; i < budget; i++) begin
      tw = ((i % 32) < 12) ? 10'h354 : random_data_word();
      for (int b = 0; b < 10; b++) sbits.push_back(tw[b]);
      for (int b = 0; b < 10; b++) rw[b] = sbits.pop_front();
      cycle(rw);
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL misaligned_stream cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
      if (i == SEARCH_CYCLES - 2 || i == SEARCH_CYCLES - 1 ||
          i == 2 * SEARCH_CYCLES - 1 || i == 3 * SEARCH_CYCLES - 1) begin
        vectors++;
        if (int'(bus.align_offset) !== (i + 1) / SEARCH_CYCLES) begin
          miscompares++;
          $display("FAIL offset_step cyc=%0d: got %0d, expected %0d", i, bus.align_offset, (i + 1) / SEARCH_CYCLES);
        end
      end
      if (bus.locked === 1'b1) begin
        got_lock = 1;
        break;
      end
    end
    vectors++;
    if (!got_lock || bus.align_offset !== 4'd3) begin
      miscompares++;
      $display("FAIL misaligned_lock: got locked=%b offset=%0d, expected locked=1 offset=3", bus.locked, bus.align_offset);
    end
  endtask

  task automatic test_loss();
    apply_reset();
    for (int i = 0; i < 16 + LOSS_CYCLES + 4; i++) begin
      cycle(i < 16 ? 10'h354 : 10'h100);
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL loss_stream cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
      if (i == 18 + LOSS_CYCLES - 1 || i == 18 + LOSS_CYCLES) begin
        vectors++;
        if ({bus.locked, bus.de} !== ((i == 18 + LOSS_CYCLES) ? 2'b00 : 2'b11)) begin
          miscompares++;
          $display("FAIL loss_edge cyc=%0d: got locked,de=%b%b", i, bus.locked, bus.de);
        end
      end
    end
`ifdef TMDS_RX_STATS_EN
    vectors++;
    if (bus.lock_loss_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL loss_count: got %0d, expected 1", bus.lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      cycle(i < 16 ? 10'h354 : random_data_word());
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("FAIL midreset_pre cyc=%0d: got %h, expected %h", i, dut_outputs(), model_outputs());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (dut_outputs() !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset_async: got %h, expected 0000", dut_outputs());
    end
    repeat (2) @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(10'h354);
    vectors++;
    if (bus.locked !== 1'b0 || bus.align_offset !== 4'd0 || dut_outputs() !== model_outputs()) begin
      miscompares++;
      $display("FAIL midreset_release: got %h, expected %h", dut_outputs(), model_outputs());
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.raw_data = '0;
    model_reset();
    test_reset();
    test_aligned_lock();
    test_decode();
    test_aborted_verify();
    test_misaligned();
    test_loss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
